// File: rtl/mario_jump_sequencer_if.sv
// Vertical-step handshake between the jump sequencer (master) and the up/down mover (slave).
// step_dy is two's complement; negative moves Mario up the screen.
interface mario_jump_sequencer_if;
    logic       step_valid;
    logic       step_ready;
    logic [7:0] step_dy;

    modport master (
        output step_valid,
        output step_dy,
        input  step_ready
    );

    modport slave (
        input  step_valid,
        input  step_dy,
        output step_ready
    );
endinterface

// File: rtl/mario_jump_sequencer.sv
// Mario vertical-motion FSM: GROUNDED -> RISING -> APEX -> FALLING, one signed dy step per movement tick.
// Optional feature: define VARIABLE_JUMP_EN to let an early jump release (after MIN_RISE pixels) cut the rise short.
module mario_jump_sequencer #(
    parameter int JUMP_HEIGHT   = 120,
    parameter int RISE_STEP     = 4,
    parameter int HANG_TICKS    = 3,
    parameter int GRAVITY_TICKS = 4,
    parameter int FALL_STEP_MAX = 6
`ifdef VARIABLE_JUMP_EN
    ,
    parameter int MIN_RISE      = 40
`endif
) (
    input  logic                          vga_clock,
    input  logic                          reset,
    input  logic                          move_tick,
    input  logic                          jump,
    input  logic                          blocked_above,
    input  logic                          blocked_below,
    mario_jump_sequencer_if.master        step,
    output logic                          airborne,
    output logic [1:0]                    jump_state
);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        APEX     = 2'd2,
        FALLING  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [15:0] juice, juice_nx;
    logic [7:0]  fall_speed, fall_speed_nx;
    logic [7:0]  hang, hang_nx;
    logic [7:0]  gravity, gravity_nx;
    logic [15:0] rise_amt;
    logic        jump_q;
    logic        jump_pending;
    logic        issue;
    logic [7:0]  issue_dy;
    logic        tick_ok;
    logic        early_release;

    // A tick is honoured only when no offered step is stalled by the mover.
    assign tick_ok = move_tick && (!step.step_valid || step.step_ready);

    assign rise_amt = (juice < 16'(RISE_STEP)) ? juice : 16'(RISE_STEP);

`ifdef VARIABLE_JUMP_EN
    assign early_release = !jump && ((16'(JUMP_HEIGHT) - juice) >= 16'(MIN_RISE));
`else
    assign early_release = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        juice_nx      = juice;
        fall_speed_nx = fall_speed;
        hang_nx       = hang;
        gravity_nx    = gravity;
        issue         = 1'b0;
        issue_dy      = 8'd0;

        case (state)
            GROUNDED: begin
                if (!blocked_below) begin
                    state_nx      = FALLING;
                    fall_speed_nx = 8'd1;
                    gravity_nx    = 8'd0;
                end else if (jump_pending && !blocked_above) begin
                    state_nx = RISING;
                    juice_nx = 16'(JUMP_HEIGHT);
                end
            end
            RISING: begin
                if (blocked_above || (juice == 16'd0) || early_release) begin
                    state_nx = APEX;
                    hang_nx  = 8'(HANG_TICKS);
                end else begin
                    issue    = 1'b1;
                    issue_dy = 8'(16'd0 - rise_amt);
                    juice_nx = juice - rise_amt;
                end
            end
            APEX: begin
                if (hang == 8'd0) begin
                    state_nx      = FALLING;
                    fall_speed_nx = 8'd1;
                    gravity_nx    = 8'd0;
                end else begin
                    hang_nx = hang - 8'd1;
                end
            end
            FALLING: begin
                if (blocked_below) begin
                    state_nx      = GROUNDED;
                    fall_speed_nx = 8'd0;
                    gravity_nx    = 8'd0;
                end else begin
                    issue    = 1'b1;
                    issue_dy = fall_speed;
                    if (gravity == 8'(GRAVITY_TICKS - 1)) begin
                        gravity_nx    = 8'd0;
                        fall_speed_nx = (fall_speed >= 8'(FALL_STEP_MAX)) ? 8'(FALL_STEP_MAX)
                                                                          : fall_speed + 8'd1;
                    end else begin
                        gravity_nx = gravity + 8'd1;
                    end
                end
            end
            default: state_nx = GROUNDED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state      <= GROUNDED;
            juice      <= 16'd0;
            fall_speed <= 8'd0;
            hang       <= 8'd0;
            gravity    <= 8'd0;
        end else if (tick_ok) begin
            state      <= state_nx;
            juice      <= juice_nx;
            fall_speed <= fall_speed_nx;
            hang       <= hang_nx;
            gravity    <= gravity_nx;
        end
    end

    // Only a fresh press while standing arms a jump; leaving the ground disarms it.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            jump_q       <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            jump_q <= jump;
            if (state == GROUNDED && tick_ok && state_nx != GROUNDED) begin
                jump_pending <= 1'b0;
            end else if (state == GROUNDED && jump && !jump_q) begin
                jump_pending <= 1'b1;
            end
        end
    end

    // A new step on the handshake cycle replaces the accepted one without a bubble.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            step.step_valid <= 1'b0;
            step.step_dy    <= 8'd0;
        end else if (tick_ok && issue) begin
            step.step_valid <= 1'b1;
            step.step_dy    <= issue_dy;
        end else if (step.step_ready) begin
            step.step_valid <= 1'b0;
            step.step_dy    <= 8'd0;
        end
    end

    assign jump_state = state;
    assign airborne   = (state != GROUNDED);

endmodule
